// File: rtl/lu_pkg.sv
// Shared constants and state encoding for the LU row store.
package lu_pkg;

  // IEEE-754 double 1.0, used by hosts building identity/pivot rows.
  localparam logic [63:0] ONE = 64'h3ff0000000000000;

  typedef logic [1:0] lu_state_t;

  localparam lu_state_t StIdle  = 2'd0;
  localparam lu_state_t StLoad  = 2'd1;
  localparam lu_state_t StServe = 2'd2;
  localparam lu_state_t StDrain = 2'd3;

endpackage

// File: rtl/lu_row_ram.sv
// Row storage: one write port, one registered read port with write-first bypass.
module lu_row_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 2048,
  parameter int unsigned AW    = 4
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lu_row_store.sv
// Matrix row store for the LU engine: host load, LU read/write-back service, ordered drain.
module lu_row_store
  import lu_pkg::*;
#(
  parameter int unsigned SIZE   = 16,
  parameter int unsigned ELEM_W = 128,
  localparam int unsigned AW    = (SIZE > 1) ? $clog2(SIZE) : 1,
  localparam int unsigned RW    = SIZE * ELEM_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          flush_i,
  input  logic [RW-1:0] load_row_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic          load_valid_i,
  output logic          load_ready_o,
  input  logic [AW-1:0] rd_addr_i,
  input  logic          rd_addr_valid_i,
  output logic [RW-1:0] rd_row_o,
  output logic [AW-1:0] rd_row_addr_o,
  output logic          rd_row_valid_o,
  input  logic [RW-1:0] wb_row_i,
  input  logic [AW-1:0] wb_addr_i,
  input  logic          wb_valid_i,
  output logic          wb_ready_o,
  output logic          lu_start_o,
  output logic [RW-1:0] out_row_o,
  output logic [AW-1:0] out_addr_o,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic          busy_o,
  output logic          done_o
);

  localparam int unsigned WbTotal = SIZE * (SIZE - 1) / 2;
  localparam int unsigned CW      = $clog2(WbTotal + 1);

  lu_state_t      state_q, state_d;
  logic [SIZE-1:0] loaded_q, loaded_d;
  logic [CW-1:0]   wb_cnt_q, wb_cnt_d;
  logic [AW-1:0]   drain_ptr_q, drain_ptr_d;
  logic            lu_start_q, lu_start_d;
  logic            done_q, done_d;
  logic            rd_vld_q, rd_vld_d;
  logic [AW-1:0]   rd_addr_q, rd_addr_d;

  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [RW-1:0]   mem_wdata;
  logic            mem_re;
  logic [AW-1:0]   mem_raddr;
  logic [RW-1:0]   mem_rdata;

  always_comb begin
    state_d     = state_q;
    loaded_d    = loaded_q;
    wb_cnt_d    = wb_cnt_q;
    drain_ptr_d = drain_ptr_q;
    lu_start_d  = 1'b0;
    done_d      = 1'b0;
    rd_vld_d    = 1'b0;
    rd_addr_d   = rd_addr_q;
    mem_we      = 1'b0;
    mem_waddr   = load_addr_i;
    mem_wdata   = load_row_i;

    if (flush_i) begin
      state_d     = StIdle;
      loaded_d    = '0;
      wb_cnt_d    = '0;
      drain_ptr_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) state_d = StLoad;
        end
        StLoad: begin
          if (load_valid_i) begin
            mem_we                = 1'b1;
            loaded_d[load_addr_i] = 1'b1;
            if (&loaded_d) begin
              state_d    = StServe;
              lu_start_d = 1'b1;
            end
          end
        end
        StServe: begin
          if (wb_valid_i) begin
            mem_we    = 1'b1;
            mem_waddr = wb_addr_i;
            mem_wdata = wb_row_i;
            wb_cnt_d  = wb_cnt_q + 1'b1;
            if (wb_cnt_d == CW'(WbTotal)) state_d = StDrain;
          end
          // The read port is claimed by the drain prefetch on the final write-back cycle.
          if (rd_addr_valid_i && (state_d == StServe)) begin
            rd_vld_d  = 1'b1;
            rd_addr_d = rd_addr_i;
          end
        end
        StDrain: begin
          if (out_ready_i) begin
            if (drain_ptr_q == AW'(SIZE - 1)) begin
              state_d     = StIdle;
              drain_ptr_d = '0;
              loaded_d    = '0;
              wb_cnt_d    = '0;
              done_d      = 1'b1;
            end else begin
              drain_ptr_d = drain_ptr_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // In DRAIN the read register always holds row[drain_ptr_q], so data is stable while stalled.
  always_comb begin
    mem_re    = rd_vld_d || (state_d == StDrain);
    mem_raddr = (state_d == StDrain) ? drain_ptr_d : rd_addr_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      loaded_q    <= '0;
      wb_cnt_q    <= '0;
      drain_ptr_q <= '0;
      lu_start_q  <= 1'b0;
      done_q      <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_addr_q   <= '0;
    end else begin
      state_q     <= state_d;
      loaded_q    <= loaded_d;
      wb_cnt_q    <= wb_cnt_d;
      drain_ptr_q <= drain_ptr_d;
      lu_start_q  <= lu_start_d;
      done_q      <= done_d;
      rd_vld_q    <= rd_vld_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  lu_row_ram #(
    .DEPTH(SIZE),
    .WIDTH(RW),
    .AW   (AW)
  ) u_ram (
    .clk_i  (clk_i),
    .we_i   (mem_we),
    .waddr_i(mem_waddr),
    .wdata_i(mem_wdata),
    .re_i   (mem_re),
    .raddr_i(mem_raddr),
    .rdata_o(mem_rdata)
  );

  assign load_ready_o   = (state_q == StLoad);
  assign wb_ready_o     = (state_q == StServe);
  assign out_valid_o    = (state_q == StDrain);
  assign busy_o         = (state_q != StIdle);
  assign out_addr_o     = drain_ptr_q;
  assign out_row_o      = mem_rdata;
  assign rd_row_o       = mem_rdata;
  assign rd_row_addr_o  = rd_addr_q;
  assign rd_row_valid_o = rd_vld_q;
  assign lu_start_o     = lu_start_q;
  assign done_o         = done_q;

endmodule

// File: doc/lu_row_store.md
LU_ROW_STORE -- requirements
Module: lu_row_store

Interface
REQ-001 Parameter SIZE, default 16, matrix dimension (rows = columns = SIZE).
REQ-002 Parameter ELEM_W, default 128, complex element width {b,a}; a is the low 64 bits and b the high 64 bits, each IEEE-754 double.
REQ-003 clk_i  in  1  single clock; all logic is rising-edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-high.
REQ-005 start_i  in  1  begin a new matrix load, accepted in IDLE only.
REQ-006 flush_i  in  1  abort the current matrix and return to IDLE.
REQ-007 load_row_i  in  SIZE*ELEM_W  host row data; load_addr_i  in  clog2(SIZE)  host row index; load_valid_i  in  1  host row valid; load_ready_o  out  1  store accepts host rows.
REQ-008 rd_addr_i  in  clog2(SIZE)  LU read address; rd_addr_valid_i  in  1  LU read request.
REQ-009 rd_row_o  out  SIZE*ELEM_W  read data; rd_row_addr_o  out  clog2(SIZE)  address of rd_row_o; rd_row_valid_o  out  1  read data valid.
REQ-010 wb_row_i  in  SIZE*ELEM_W  LU updated row; wb_addr_i  in  clog2(SIZE)  its index; wb_valid_i  in  1  write-back valid; wb_ready_o  out  1  write-back accepted.
REQ-011 lu_start_o  out  1  one-cycle start pulse to LU.
REQ-012 out_row_o  out  SIZE*ELEM_W  drained row; out_addr_o  out  clog2(SIZE)  its index; out_valid_o  out  1  drained row valid; out_ready_i  in  1  sink ready.
REQ-013 busy_o  out  1  state != IDLE; done_o  out  1  one-cycle pulse after the last drained row.

Function
REQ-014 States are IDLE, LOAD, SERVE, DRAIN; IDLE->LOAD on start_i; LOAD->SERVE when all SIZE rows are loaded; SERVE->DRAIN when the write-back count reaches SIZE*(SIZE-1)/2; DRAIN->IDLE on acceptance of row SIZE-1.
REQ-015 LOAD: load_ready_o=1, and load_valid_i writes load_row_i into row load_addr_i and sets loaded[load_addr_i].
REQ-016 A repeated load address SHALL overwrite the row; the loaded bitmap is unchanged.
REQ-017 In all states other than LOAD, load_ready_o=0 and host rows are ignored.
REQ-018 lu_start_o SHALL pulse exactly one cycle, in the first SERVE cycle.
REQ-019 SERVE read: rd_addr_valid_i at cycle N gives rd_row_valid_o=1, rd_row_addr_o=rd_addr_i and rd_row_o=row[rd_addr_i] at cycle N+1; rd_row_valid_o=0 otherwise.
REQ-020 SERVE: wb_ready_o=1; a write-back writes the row and increments wb_cnt, of width clog2(SIZE*(SIZE-1)/2+1).
REQ-021 A read and a write-back to the same address in the same cycle SHALL return the newly written row (write-first bypass).
REQ-022 Outside SERVE, wb_ready_o=0, reads are ignored and rd_row_valid_o=0.
REQ-023 DRAIN: out_row_o=row[drain_ptr], out_addr_o=drain_ptr, out_valid_o=1, and drain_ptr increments on out_valid_o & out_ready_i.
REQ-024 DRAIN: data SHALL be held stable while out_ready_i=0.
REQ-025 done_o SHALL pulse in the cycle after row SIZE-1 is accepted, with state IDLE.
REQ-026 flush_i in any state forces IDLE next cycle and clears the bitmap, wb_cnt and drain_ptr; row contents are don't-care.
REQ-027 flush_i has priority over start_i and all handshakes in the same cycle.
REQ-028 start_i outside IDLE SHALL be ignored.

Reset
REQ-029 Asserting rst_i SHALL immediately force state=IDLE, bitmap=0, wb_cnt=0, drain_ptr=0.
REQ-030 During and after reset until stimulus, all valid, ready and pulse outputs are 0; rd_row_addr_o and out_addr_o are 0; row storage is not reset.
REQ-031 Reset asserted mid-SERVE or mid-DRAIN behaves identically to REQ-029 and REQ-030.

Structure
REQ-032 The state enum and the ONE constant 64'h3ff0000000000000 SHALL reside in shared package lu_pkg.
REQ-033 Row storage SHALL be a separate sub-module lu_row_ram with one write port and one registered read port with write-first bypass.

Verification
REQ-034 Load rows 0..15 in order, each element {0,i+1.0} -> lu_start_o pulses in the cycle after the load of row 15; load_ready_o=0 thereafter.
REQ-035 Load row 3 twice (values 1.0 then 2.0) plus all other rows -> the SERVE read of row 3 returns 2.0 and the transition occurs only after all 16 indices are seen.
REQ-036 SERVE read addr 5 at cycle N, write-back row 5=7.0 at cycle N -> rd_row_o=7.0, rd_row_addr_o=5 at cycle N+1.
REQ-037 Issue 120 write-backs -> DRAIN is entered after the 120th; DRAIN with out_ready_i toggling 1010... -> rows 0..15 are emitted in order, held while stalled, and done_o pulses once.
REQ-038 Assert flush_i in SERVE after 60 write-backs -> IDLE next cycle with busy_o=0; a new start_i with a full load yields a fresh lu_start_o.
REQ-039 Assert rst_i asynchronously mid-DRAIN at drain_ptr=7 -> outputs zero without a clock edge, and state=IDLE after release.
